// File: rtl/prim_ram_1p_req_adapter.sv
// Valid/ready front end for a 1-cycle-latency single-port SRAM, with a credit-bounded response FIFO.
// Optional: define PRIM_RAM_1P_ADAPTER_WRITE_ACK_EN to return an ordered ack for every accepted write.
module prim_ram_1p_req_adapter #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 128,
  parameter int unsigned RspDepth = 2,
  localparam int unsigned Aw      = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Aw-1:0]    req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [Width-1:0] req_wmask_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_write_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam int unsigned PW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CW = $clog2(RspDepth + 1);

  logic             infl_q, infl_d;
  logic             infl_wr_q, infl_wr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [Width-1:0] data_q [RspDepth];
  logic [CW-1:0]    cnt;
  logic             accept, take, push, pop, full;

  assign push = infl_q;
  assign pop  = rsp_valid_o & rsp_ready_i;
  assign full = (occ_q == CW'(RspDepth));
  assign cnt  = occ_q + CW'(infl_q);

  // A pop this cycle frees its credit immediately, so a full pipe still accepts.
  assign req_ready_o = rst_ni & ((cnt < CW'(RspDepth)) | pop);
  assign accept      = req_valid_i & req_ready_o;

  assign ram_req_o   = accept;
  assign ram_write_o = req_write_i;
  assign ram_addr_o  = req_addr_i;
  assign ram_wdata_o = req_wdata_i;
  assign ram_wmask_o = req_wmask_i;

`ifdef PRIM_RAM_1P_ADAPTER_WRITE_ACK_EN
  assign take      = accept;
  assign infl_wr_d = accept & req_write_i;
`else
  assign take      = accept & ~req_write_i;
  assign infl_wr_d = 1'b0;
`endif
  assign infl_d = take;
  assign occ_d  = occ_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      infl_q    <= 1'b0;
      infl_wr_q <= 1'b0;
      occ_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      infl_q    <= infl_d;
      infl_wr_q <= infl_wr_d;
      occ_q     <= occ_d;
      if (push) wptr_q <= (wptr_q == PW'(RspDepth - 1)) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == PW'(RspDepth - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until occ_q says so.
  always_ff @(posedge clk_i) begin
    if (push) data_q[wptr_q] <= infl_wr_q ? '0 : ram_rdata_i;
  end

  assign rsp_valid_o = (occ_q != '0);
  assign rsp_rdata_o = rsp_valid_o ? data_q[rptr_q] : '0;

`ifdef PRIM_RAM_1P_ADAPTER_WRITE_ACK_EN
  logic wr_q [RspDepth];
  always_ff @(posedge clk_i) begin
    if (push) wr_q[wptr_q] <= infl_wr_q;
  end
  assign rsp_write_o = rsp_valid_o & wr_q[rptr_q];
`else
  assign rsp_write_o = 1'b0;
`endif

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));

endmodule
